// File: rtl/mem_port_arbiter.sv
// N-to-1 round-robin memory port arbiter with a one-deep request latch per client.
// Latency: client strobe at t -> ctrl strobe at t+2 when idle; ready/q routed combinationally.
// Backpressure: ctrl_available low holds arbitration; clients see cl_available low while pending.
module mem_port_arbiter #(
    parameter int NUM_PORTS         = 4,
    parameter int PORT_ADDR_WIDTH   = 21,
    parameter int DATA_WIDTH        = 16,
    parameter int DQM_WIDTH         = 2,
    parameter int PORT_OUTPUT_WIDTH = 32,
    parameter int BURST_BEATS       = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS*PORT_ADDR_WIDTH-1:0] cl_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      cl_data,
    input  logic [NUM_PORTS*DQM_WIDTH-1:0]       cl_byte_en,
    input  logic [NUM_PORTS-1:0]                 cl_wr,
    input  logic [NUM_PORTS-1:0]                 cl_rd,
    input  logic [NUM_PORTS-1:0]                 cl_burst,
    output logic [PORT_OUTPUT_WIDTH-1:0]         cl_q,
    output logic [NUM_PORTS-1:0]                 cl_available,
    output logic [NUM_PORTS-1:0]                 cl_ready,
    output logic [PORT_ADDR_WIDTH-1:0]           ctrl_addr,
    output logic [DATA_WIDTH-1:0]                ctrl_data,
    output logic [DQM_WIDTH-1:0]                 ctrl_byte_en,
    output logic                                 ctrl_wr,
    output logic                                 ctrl_rd,
    output logic                                 ctrl_burst,
    input  logic [PORT_OUTPUT_WIDTH-1:0]         ctrl_q,
    input  logic                                 ctrl_available,
    input  logic                                 ctrl_ready
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(BURST_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Per-client request latches
    logic [NUM_PORTS-1:0]       pending_q;
    logic [PORT_ADDR_WIDTH-1:0] p_addr_q  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]      p_data_q  [NUM_PORTS];
    logic [DQM_WIDTH-1:0]       p_ben_q   [NUM_PORTS];
    logic [NUM_PORTS-1:0]       p_wr_q;
    logic [NUM_PORTS-1:0]       p_burst_q;

    // Arbitration / transaction state
    state_t                     state_q;
    logic [PW-1:0]              grant_q;
    logic [PW-1:0]              ptr_q;
    logic [CW-1:0]              beats_q;
    logic [PORT_ADDR_WIDTH-1:0] ctrl_addr_q;
    logic [DATA_WIDTH-1:0]      ctrl_data_q;
    logic [DQM_WIDTH-1:0]       ctrl_ben_q;
    logic                       ctrl_wr_q;
    logic                       ctrl_rd_q;
    logic                       ctrl_burst_q;

    // Next-state helpers
    logic [NUM_PORTS-1:0]       cap_d;
    logic [NUM_PORTS-1:0]       clr_mask_d;
    logic [NUM_PORTS-1:0]       pending_d;
    logic                       any_pend_d;
    logic [PW-1:0]              grant_d;
    logic [PW-1:0]              cand;
    logic [CW-1:0]              beats_exp_d;
    logic [CW-1:0]              beats_left_d;
    logic                       done_d;

    // Round-robin search: first pending port after the last one served
    always_comb begin
        any_pend_d = 1'b0;
        grant_d    = ptr_q;
        cand       = ptr_q;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PW'((int'(ptr_q) + k) % NUM_PORTS);
            if (!any_pend_d && pending_q[cand]) begin
                any_pend_d = 1'b1;
                grant_d    = cand;
            end
        end
    end

    // Beat accounting; a ready arriving alongside the strobe already counts
    always_comb begin
        beats_exp_d  = (ctrl_wr_q || !ctrl_burst_q) ? CW'(1) : CW'(BURST_BEATS);
        beats_left_d = beats_exp_d - CW'(ctrl_ready);
        done_d       = ((state_q == ST_ISSUE) && (beats_left_d == '0)) ||
                       ((state_q == ST_WAIT) && ctrl_ready && (beats_q == CW'(1)));
        clr_mask_d   = done_d ? (NUM_PORTS'(1) << grant_q) : '0;
        cap_d        = (cl_rd | cl_wr) & ~pending_q;
        pending_d    = (pending_q | cap_d) & ~clr_mask_d;
    end

    // Capture client requests into free latches; release on final beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            p_wr_q    <= '0;
            p_burst_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                p_addr_q[i] <= '0;
                p_data_q[i] <= '0;
                p_ben_q[i]  <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (cap_d[i]) begin
                    p_addr_q[i]  <= cl_addr[i*PORT_ADDR_WIDTH +: PORT_ADDR_WIDTH];
                    p_data_q[i]  <= cl_data[i*DATA_WIDTH +: DATA_WIDTH];
                    p_ben_q[i]   <= cl_byte_en[i*DQM_WIDTH +: DQM_WIDTH];
                    // write wins when both strobes are high; burst only qualifies reads
                    p_wr_q[i]    <= cl_wr[i];
                    p_burst_q[i] <= cl_rd[i] & cl_burst[i] & ~cl_wr[i];
                end
            end
        end
    end

    // Transaction FSM with registered controller-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            ptr_q        <= PW'(NUM_PORTS - 1);
            beats_q      <= '0;
            ctrl_addr_q  <= '0;
            ctrl_data_q  <= '0;
            ctrl_ben_q   <= '0;
            ctrl_wr_q    <= 1'b0;
            ctrl_rd_q    <= 1'b0;
            ctrl_burst_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_pend_d && ctrl_available) begin
                        grant_q      <= grant_d;
                        ctrl_addr_q  <= p_addr_q[grant_d];
                        ctrl_data_q  <= p_data_q[grant_d];
                        ctrl_ben_q   <= p_ben_q[grant_d];
                        ctrl_wr_q    <= p_wr_q[grant_d];
                        ctrl_rd_q    <= ~p_wr_q[grant_d];
                        ctrl_burst_q <= p_burst_q[grant_d];
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    ctrl_wr_q    <= 1'b0;
                    ctrl_rd_q    <= 1'b0;
                    ctrl_burst_q <= 1'b0;
                    beats_q      <= beats_left_d;
                    if (done_d) begin
                        ptr_q   <= grant_q;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ctrl_ready) begin
                        beats_q <= beats_q - CW'(1);
                        if (done_d) begin
                            ptr_q   <= grant_q;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Route controller beats only to the port in service
    always_comb begin
        cl_ready = '0;
        if ((state_q != ST_IDLE) && ctrl_ready) begin
            cl_ready[grant_q] = 1'b1;
        end
    end

    assign cl_available = ~pending_q;
    assign cl_q         = ctrl_q;
    assign ctrl_addr    = ctrl_addr_q;
    assign ctrl_data    = ctrl_data_q;
    assign ctrl_byte_en = ctrl_ben_q;
    assign ctrl_wr      = ctrl_wr_q;
    assign ctrl_rd      = ctrl_rd_q;
    assign ctrl_burst   = ctrl_burst_q;

endmodule
